// File: rtl/matmul_pkg.sv
// Shared definitions for the matmul_accel bus-mapped matrix engine:
// register offsets, control/status bit positions and the FSM state type.
package matmul_pkg;

    localparam logic [11:0] OFF_CTRL   = 12'h000;
    localparam logic [11:0] OFF_STATUS = 12'h004;
    localparam logic [11:0] OFF_CYCLES = 12'h008;
    localparam logic [11:0] OFF_A_BASE = 12'h100;
    localparam logic [11:0] OFF_B_BASE = 12'h200;
    localparam logic [11:0] OFF_C_BASE = 12'h300;

    localparam int CTRL_START  = 0;
    localparam int CTRL_ACCUM  = 1;
    localparam int CTRL_IRQ_EN = 2;

    localparam int ST_BUSY = 0;
    localparam int ST_DONE = 1;

    typedef enum logic [1:0] {
        S_IDLE,
        S_MAC,
        S_WB,
        S_DONE
    } state_e;

endpackage

// File: rtl/matmul_accel_mac.sv
// Combinational signed multiply-accumulate: acc + sext(a*b),
// wrapping modulo 2^ACC_W.
module matmul_mac #(
    parameter int DATA_W = 16,
    parameter int ACC_W  = 32
) (
    input  logic signed [DATA_W-1:0] a_i,
    input  logic signed [DATA_W-1:0] b_i,
    input  logic signed [ACC_W-1:0]  acc_i,
    output logic signed [ACC_W-1:0]  sum_o
);

    logic signed [2*DATA_W-1:0] prod;

    assign prod  = a_i * b_i;
    assign sum_o = acc_i + ACC_W'(prod);

endmodule

// File: rtl/matmul_accel.sv
// Memory-mapped NxN signed matrix multiply engine, one MAC per cycle.
// Optional MATMUL_ACCEL_IRQ_EN adds an irq output and CTRL bit2 IRQ_EN.
module matmul_accel
    import matmul_pkg::*;
#(
    parameter int          N         = 4,
    parameter int          DATA_W    = 16,
    parameter int          ACC_W     = 32,
    parameter logic [31:0] BASE_ADDR = 32'h0200_0000
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic        mem_valid,
    output logic        mem_ready,
    input  logic [31:0] mem_addr,
    input  logic [31:0] mem_wdata,
    input  logic [3:0]  mem_wstrb,
    output logic [31:0] mem_rdata
`ifdef MATMUL_ACCEL_IRQ_EN
    ,
    output logic        irq
`endif
);

    localparam int NN = N * N;
    localparam int IW = (NN > 1) ? $clog2(NN) : 1;
    localparam int CW = (N > 1) ? $clog2(N) : 1;

    logic signed [DATA_W-1:0] a_mem [NN];
    logic signed [DATA_W-1:0] b_mem [NN];
    logic signed [ACC_W-1:0]  c_mem [NN];

    state_e            state_q, state_d;
    logic [CW-1:0]     i_q, i_d, j_q, j_d, k_q, k_d;
    logic signed [ACC_W-1:0] acc_q, acc_d;
    logic              accum_q, accum_d;
    logic              done_q, done_d;
    logic [31:0]       cycles_q, cycles_d;
    logic              ready_q;
    logic [31:0]       rdata_q;
    logic              c_we;

    logic              in_win, accept, is_wr, busy;
    logic [11:0]       off;
    logic [5:0]        widx;
    logic              idx_ok;
    logic [IW-1:0]     bus_idx, a_idx, b_idx, e_idx, e_nxt;
    logic              ctrl_wr, start, st_clr, wr_a, wr_b, last;
    logic signed [ACC_W-1:0] mac_sum;
    logic [31:0]       rd_val;
    logic              irq_en_q;
    logic              unused_ok;

    assign unused_ok = ^{mem_addr[1:0], mem_wdata};

    assign off     = {mem_addr[11:2], 2'b00};
    assign widx    = mem_addr[7:2];
    assign idx_ok  = int'(widx) < NN;
    assign bus_idx = IW'(widx);

    assign in_win = mem_addr[31:12] == BASE_ADDR[31:12];
    assign accept = resetn && mem_valid && in_win && !ready_q;
    assign is_wr  = |mem_wstrb;
    assign busy   = (state_q == S_MAC) || (state_q == S_WB);

    assign ctrl_wr = accept && is_wr && (off == OFF_CTRL);
    assign start   = ctrl_wr && !busy && (state_q == S_IDLE)
                     && mem_wdata[CTRL_START];
    assign st_clr  = accept && is_wr && (off == OFF_STATUS)
                     && mem_wdata[ST_DONE];
    assign wr_a    = accept && is_wr && !busy && idx_ok
                     && (off[11:8] == OFF_A_BASE[11:8]);
    assign wr_b    = accept && is_wr && !busy && idx_ok
                     && (off[11:8] == OFF_B_BASE[11:8]);

    assign a_idx = IW'(int'(i_q) * N + int'(k_q));
    assign b_idx = IW'(int'(k_q) * N + int'(j_q));
    assign e_idx = IW'(int'(i_q) * N + int'(j_q));
    assign e_nxt = e_idx + 1'b1;
    assign last  = (i_q == CW'(N - 1)) && (j_q == CW'(N - 1));

    matmul_mac #(
        .DATA_W (DATA_W),
        .ACC_W  (ACC_W)
    ) u_mac (
        .a_i   (a_mem[a_idx]),
        .b_i   (b_mem[b_idx]),
        .acc_i (acc_q),
        .sum_o (mac_sum)
    );

    // Read-data mux for the register map and the three buffers.
    always_comb begin
        rd_val = '0;
        if (off == OFF_CTRL) begin
            rd_val[CTRL_ACCUM] = accum_q;
`ifdef MATMUL_ACCEL_IRQ_EN
            rd_val[CTRL_IRQ_EN] = irq_en_q;
`endif
        end else if (off == OFF_STATUS) begin
            rd_val[ST_BUSY] = busy;
            rd_val[ST_DONE] = done_q;
        end else if (off == OFF_CYCLES) begin
            rd_val = cycles_q;
        end else if (idx_ok) begin
            if (off[11:8] == OFF_A_BASE[11:8]) begin
                rd_val = 32'(a_mem[bus_idx]);
            end else if (off[11:8] == OFF_B_BASE[11:8]) begin
                rd_val = 32'(b_mem[bus_idx]);
            end else if (off[11:8] == OFF_C_BASE[11:8]) begin
                rd_val = 32'(c_mem[bus_idx]);
            end
        end
    end

    // Compute FSM next state and datapath updates.
    always_comb begin
        state_d  = state_q;
        i_d      = i_q;
        j_d      = j_q;
        k_d      = k_q;
        acc_d    = acc_q;
        accum_d  = accum_q;
        done_d   = done_q;
        cycles_d = cycles_q;
        c_we     = 1'b0;

        if (st_clr) begin
            done_d = 1'b0;
        end
        if (ctrl_wr && !busy) begin
            accum_d = mem_wdata[CTRL_ACCUM];
        end
        if (busy) begin
            cycles_d = cycles_q + 32'd1;
        end

        unique case (state_q)
            S_IDLE: begin
                if (start) begin
                    done_d   = 1'b0;
                    cycles_d = '0;
                    i_d      = '0;
                    j_d      = '0;
                    k_d      = '0;
                    acc_d    = mem_wdata[CTRL_ACCUM] ? c_mem[0] : '0;
                    state_d  = S_MAC;
                end
            end
            S_MAC: begin
                acc_d = mac_sum;
                if (k_q == CW'(N - 1)) begin
                    state_d = S_WB;
                end else begin
                    k_d = k_q + 1'b1;
                end
            end
            S_WB: begin
                c_we = 1'b1;
                if (last) begin
                    state_d = S_DONE;
                end else begin
                    if (j_q == CW'(N - 1)) begin
                        j_d = '0;
                        i_d = i_q + 1'b1;
                    end else begin
                        j_d = j_q + 1'b1;
                    end
                    k_d     = '0;
                    acc_d   = accum_q ? c_mem[e_nxt] : '0;
                    state_d = S_MAC;
                end
            end
            S_DONE: begin
                done_d  = 1'b1;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // FSM and datapath registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            state_q  <= S_IDLE;
            i_q      <= '0;
            j_q      <= '0;
            k_q      <= '0;
            acc_q    <= '0;
            accum_q  <= 1'b0;
            done_q   <= 1'b0;
            cycles_q <= '0;
        end else begin
            state_q  <= state_d;
            i_q      <= i_d;
            j_q      <= j_d;
            k_q      <= k_d;
            acc_q    <= acc_d;
            accum_q  <= accum_d;
            done_q   <= done_d;
            cycles_q <= cycles_d;
        end
    end

    // Bus acknowledge pulse and registered read data.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            ready_q <= 1'b0;
            rdata_q <= '0;
        end else begin
            ready_q <= accept;
            rdata_q <= accept ? rd_val : '0;
        end
    end

    // Operand and result buffers; contents survive reset.
    always_ff @(posedge clk) begin
        if (wr_a) begin
            a_mem[bus_idx] <= mem_wdata[DATA_W-1:0];
        end
        if (wr_b) begin
            b_mem[bus_idx] <= mem_wdata[DATA_W-1:0];
        end
        if (c_we && resetn) begin
            c_mem[e_idx] <= acc_q;
        end
    end

`ifdef MATMUL_ACCEL_IRQ_EN
    logic irq_q;

    // Interrupt enable and registered interrupt output.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            irq_en_q <= 1'b0;
            irq_q    <= 1'b0;
        end else begin
            if (ctrl_wr) begin
                irq_en_q <= mem_wdata[CTRL_IRQ_EN];
            end
            irq_q <= done_q & irq_en_q;
        end
    end

    assign irq = irq_q;
`else
    assign irq_en_q = 1'b0;
`endif

    assign mem_ready = ready_q;
    assign mem_rdata = rdata_q;

endmodule
